// File: rtl/hif_xbus_arb.sv
// hif_xbus_arb: lets NUM_CH serial host cores share one xbus into the register file.
// Features: round-robin arbitration, session locking on ch_active, address-range and
// testmode checking, registered xbus outputs and a registered hif_idle flag.
// Optional feature (define HIF_ERR_CNT_EN): saturating 8-bit count of rejected accesses,
// with ports err_cnt_clr / err_cnt.
module hif_xbus_arb #(
  parameter int         NUM_CH            = 2,
  parameter int         XBUS_ADDR_WIDTH   = 7,
  parameter logic [7:0] MAX_NOR_REG_ADDR  = 8'h64,
  parameter logic [7:0] MAX_TEST_REG_ADDR = 8'h65,
  localparam int        IDW               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CH-1:0]                 ch_en,
  input  logic [NUM_CH-1:0]                 ch_active,
  input  logic [NUM_CH-1:0]                 ch_req,
  input  logic [NUM_CH-1:0]                 ch_wr,
  input  logic [NUM_CH*XBUS_ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*8-1:0]               ch_din,
  output logic [NUM_CH-1:0]                 ch_ack,
  output logic [NUM_CH-1:0]                 ch_err,
  output logic [7:0]                        ch_dout,
  input  logic                              testmode_en,
  output logic [XBUS_ADDR_WIDTH-1:0]        xbus_addr,
  output logic                              xbus_wr,
  output logic [7:0]                        xbus_din,
  input  logic [7:0]                        xbus_dout,
`ifdef HIF_ERR_CNT_EN
  input  logic                              err_cnt_clr,
  output logic [7:0]                        err_cnt,
`endif
  output logic [IDW-1:0]                    grant_id,
  output logic                              hif_idle
);

  localparam int AW = XBUS_ADDR_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK, ST_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            owner_vld_q, owner_vld_d;
  logic [IDW-1:0]  owner_id_q, owner_id_d;
  logic            legal_q, legal_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   xbus_addr_q, xbus_addr_d;
  logic [7:0]      xbus_din_q, xbus_din_d;
  logic            xbus_wr_q, xbus_wr_d;
  logic [NUM_CH-1:0] ch_ack_q, ch_ack_d;
  logic [NUM_CH-1:0] ch_err_q, ch_err_d;
  logic [7:0]      ch_dout_q, ch_dout_d;
  logic            hif_idle_q, hif_idle_d;

  // Unpacked views of the packed per-channel address/data buses
  logic [AW-1:0]   addr_arr [NUM_CH];
  logic [7:0]      din_arr  [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign addr_arr[gi] = ch_addr[gi*AW +: AW];
      assign din_arr[gi]  = ch_din[gi*8 +: 8];
    end
  endgenerate

  logic              lock_eff;
  logic [NUM_CH-1:0] owner_mask;
  logic [NUM_CH-1:0] eligible;
  logic              found;
  logic [IDW-1:0]    pick;
  logic [7:0]        pick_addr8;
  logic              pick_legal;

  // Eligibility mask and round-robin pick starting at the pointer
  always_comb begin
    lock_eff   = owner_vld_q & ch_active[owner_id_q] & ch_en[owner_id_q];
    owner_mask = NUM_CH'(1) << owner_id_q;
    eligible   = ch_req & ch_en & (lock_eff ? owner_mask : {NUM_CH{1'b1}});
    found      = 1'b0;
    pick       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && eligible[IDW'((int'(rr_ptr_q) + i) % NUM_CH)]) begin
        found = 1'b1;
        pick  = IDW'((int'(rr_ptr_q) + i) % NUM_CH);
      end
    end
    pick_addr8 = 8'(addr_arr[pick]);
    pick_legal = (pick_addr8 <= MAX_NOR_REG_ADDR) ||
                 (testmode_en && (pick_addr8 <= MAX_TEST_REG_ADDR));
  end

  // Next-state and output computation for the access FSM
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    owner_vld_d = owner_vld_q;
    owner_id_d  = owner_id_q;
    legal_d     = legal_q;
    wr_d        = wr_q;
    xbus_addr_d = xbus_addr_q;
    xbus_din_d  = xbus_din_q;
    xbus_wr_d   = 1'b0;
    ch_ack_d    = '0;
    ch_err_d    = '0;
    ch_dout_d   = ch_dout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d     = pick;
          rr_ptr_d    = (pick == IDW'(NUM_CH - 1)) ? '0 : pick + 1'b1;
          owner_vld_d = ch_active[pick];
          owner_id_d  = pick;
          legal_d     = pick_legal;
          wr_d        = ch_wr[pick];
          xbus_addr_d = addr_arr[pick];
          xbus_din_d  = din_arr[pick];
          xbus_wr_d   = ch_wr[pick] & pick_legal;
          state_d     = ST_ACCESS;
        end else begin
          // Owner drops its session (or is disabled): lock released here
          owner_vld_d = lock_eff;
        end
      end
      ST_ACCESS: begin
        ch_dout_d = (legal_q && !wr_q) ? xbus_dout : 8'h00;
        ch_ack_d  = NUM_CH'(1) << grant_q;
        ch_err_d  = legal_q ? '0 : (NUM_CH'(1) << grant_q);
        state_d   = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // A request held high never gets a second ack
        if (!ch_req[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    hif_idle_d = (state_d == ST_IDLE) & ~owner_vld_d & ~|(ch_active & ch_en);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      owner_vld_q <= 1'b0;
      owner_id_q  <= '0;
      legal_q     <= 1'b0;
      wr_q        <= 1'b0;
      xbus_addr_q <= '0;
      xbus_din_q  <= '0;
      xbus_wr_q   <= 1'b0;
      ch_ack_q    <= '0;
      ch_err_q    <= '0;
      ch_dout_q   <= '0;
      hif_idle_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_vld_q <= owner_vld_d;
      owner_id_q  <= owner_id_d;
      legal_q     <= legal_d;
      wr_q        <= wr_d;
      xbus_addr_q <= xbus_addr_d;
      xbus_din_q  <= xbus_din_d;
      xbus_wr_q   <= xbus_wr_d;
      ch_ack_q    <= ch_ack_d;
      ch_err_q    <= ch_err_d;
      ch_dout_q   <= ch_dout_d;
      hif_idle_q  <= hif_idle_d;
    end
  end

`ifdef HIF_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating reject counter; clear has priority over increment
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = 8'h00;
    end else if ((state_q == ST_ACK) && !legal_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'h01;
    end
  end

  // Reject counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'h00;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign ch_ack    = ch_ack_q;
  assign ch_err    = ch_err_q;
  assign ch_dout   = ch_dout_q;
  assign xbus_addr = xbus_addr_q;
  assign xbus_wr   = xbus_wr_q;
  assign xbus_din  = xbus_din_q;
  assign grant_id  = grant_q;
  assign hif_idle  = hif_idle_q;

endmodule
